pipeline_hazard_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage RV32I pipeline. It generates the stall, flush and redirect controls that drive the program counter and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, EX-stage redirects (taken branch/jump), and data-memory wait states. It also covers refill of the synchronous instruction memory after a redirect, and keeps hazard performance counters.

---
 rtl/hazard_pkg.sv | 12 +
 rtl/hazard_detect.sv | 30 +++
 rtl/pipeline_hazard_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the RV32I pipeline hazard controller.
// Contents: FSM state encoding (legacy-compatible 2-bit constants) and the
// hard-wired zero register index.
package hazard_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_REFILL   = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Purely combinational load-use comparator.
// Ports:
//   id_rs1_i, id_rs2_i         source register indices of the ID instruction
//   id_use_rs1_i, id_use_rs2_i ID instruction actually reads rs1 / rs2
//   ex_rd_i                    destination register of the EX instruction
//   ex_mem_read_i              EX instruction is a load
//   load_use_o                 ID needs a value the EX load has not produced yet
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_use_rs1_i,
  input  logic       id_use_rs2_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_mem_read_i,
  output logic       load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use_rs1_i && (id_rs1_i == ex_rd_i);
  assign rs2_hit = id_use_rs2_i && (id_rs2_i == ex_rd_i);

  // x0 is hard-wired to zero, so a load targeting it never produces a value
  // anyone waits for.
  assign load_use_o = ex_mem_read_i && (ex_rd_i != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall / flush / redirect controller for the 5-stage RV32I pipeline.
// Ports:
//   clk, rst_                    clock, asynchronous active-low reset
//   id_rs1, id_rs2, id_use_rs1/2 ID-stage source operands
//   ex_rd, ex_mem_read           EX-stage destination and load flag
//   ex_redirect, ex_target       taken branch / jump resolved in EX
//   dmem_req, dmem_ready         MEM-stage access handshake
//   pc_stall, pc_redirect        PC hold / load pc_target
//   pc_target                    redirect address (ex_target passed through)
//   if_id_stall/flush            IF/ID hold / insert NOP
//   id_ex_stall/flush            ID/EX hold / insert bubble
//   ex_mem_stall                 EX/MEM hold
//   mem_wb_flush                 MEM/WB insert bubble
//   mem_timeout                  sticky data-memory timeout flag
//   stall_cycles, redirect_count performance counters (wrap modulo 2^CNT_W)
// All control outputs are combinational from state and inputs (zero latency)
// and are forced to 0 while rst_ is low.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned IMEM_LAT    = 1,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_target,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             pc_redirect,
  output logic [31:0]      pc_target,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             mem_wb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirect_count
);

  localparam logic [1:0]  REFILL_INIT = 2'(IMEM_LAT);
  localparam logic [15:0] TIMEOUT_LIM = 16'(MEM_TIMEOUT);
  localparam logic [15:0] WAIT_MAX    = 16'hFFFF;

  logic [1:0]       state_q, state_d;
  logic [1:0]       ret_q, ret_d;
  logic [1:0]       refill_q, refill_d;
  logic [15:0]      wait_q, wait_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] redir_q, redir_d;

  logic [1:0] eff_state;
  logic       mem_wait;
  logic       in_refill;
  logic       take_redirect;
  logic       load_use_raw;
  logic       load_use;

  logic pc_stall_c, pc_redirect_c, if_id_stall_c, if_id_flush_c;
  logic id_ex_stall_c, id_ex_flush_c, ex_mem_stall_c, mem_wb_flush_c;

  hazard_detect u_detect (
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_use_rs1_i  (id_use_rs1),
    .id_use_rs2_i  (id_use_rs2),
    .ex_rd_i       (ex_rd),
    .ex_mem_read_i (ex_mem_read),
    .load_use_o    (load_use_raw)
  );

  // While waiting on memory, the state we came from still decides what
  // happens the moment the wait ends, so decisions use the effective state.
  assign eff_state = (state_q == ST_MEM_WAIT) ? ret_q : state_q;
  assign in_refill = (eff_state == ST_REFILL);

  // Priority: memory wait > redirect > refill > load-use.
  assign mem_wait      = dmem_req && !dmem_ready;
  assign take_redirect = ex_redirect && !mem_wait;
  // The ID instruction is garbage during refill or when about to be flushed.
  assign load_use      = load_use_raw && !mem_wait && !ex_redirect && !in_refill;

  assign pc_stall_c     = mem_wait || load_use;
  assign pc_redirect_c  = take_redirect;
  assign if_id_stall_c  = mem_wait || load_use;
  assign if_id_flush_c  = !mem_wait && (ex_redirect || in_refill);
  assign id_ex_stall_c  = mem_wait;
  assign id_ex_flush_c  = take_redirect || load_use;
  assign ex_mem_stall_c = mem_wait;
  assign mem_wb_flush_c = mem_wait;

  assign pc_stall       = rst_ && pc_stall_c;
  assign pc_redirect    = rst_ && pc_redirect_c;
  assign pc_target      = rst_ ? ex_target : 32'd0;
  assign if_id_stall    = rst_ && if_id_stall_c;
  assign if_id_flush    = rst_ && if_id_flush_c;
  assign id_ex_stall    = rst_ && id_ex_stall_c;
  assign id_ex_flush    = rst_ && id_ex_flush_c;
  assign ex_mem_stall   = rst_ && ex_mem_stall_c;
  assign mem_wb_flush   = rst_ && mem_wb_flush_c;
  assign mem_timeout    = timeout_q;
  assign stall_cycles   = stall_q;
  assign redirect_count = redir_q;

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    refill_d  = refill_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;

    if (mem_wait) begin
      // Refill countdown is frozen along with the rest of the pipeline.
      state_d = ST_MEM_WAIT;
      if (state_q != ST_MEM_WAIT) begin
        ret_d = state_q;
      end
      if (wait_q != WAIT_MAX) begin
        wait_d = wait_q + 16'd1;
      end
      if (wait_d >= TIMEOUT_LIM) begin
        timeout_d = 1'b1;
      end
    end else begin
      wait_d = '0;
      if (take_redirect) begin
        if (IMEM_LAT > 0) begin
          state_d  = ST_REFILL;
          refill_d = REFILL_INIT;
        end else begin
          state_d  = ST_RUN;
          refill_d = '0;
        end
      end else if (in_refill) begin
        if (refill_q <= 2'd1) begin
          state_d  = ST_RUN;
          refill_d = '0;
        end else begin
          state_d  = ST_REFILL;
          refill_d = refill_q - 2'd1;
        end
      end else begin
        state_d = ST_RUN;
      end
    end
  end

  assign stall_d = pc_stall_c    ? stall_q + CNT_W'(1) : stall_q;
  assign redir_d = pc_redirect_c ? redir_q + CNT_W'(1) : redir_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q   <= ST_RUN;
      ret_q     <= ST_RUN;
      refill_q  <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      redir_q   <= '0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      refill_q  <= refill_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
      redir_q   <= redir_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (IMEM_LAT=1,
// MEM_TIMEOUT=4). Expected control vectors are queued when stimulus is
// applied and popped at the following falling edge for comparison.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect;
  logic [31:0] ex_target;
  logic        dmem_req, dmem_ready;
  logic        pc_stall, pc_redirect, if_id_stall, if_id_flush;
  logic        id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush, mem_timeout;
  logic [31:0] pc_target, stall_cycles, redirect_count;

  pipeline_hazard_ctrl #(.IMEM_LAT(1), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst_(rst_),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .ex_target(ex_target),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .mem_wb_flush(mem_wb_flush),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .redirect_count(redirect_count)
  );

  always #5 clk = ~clk;

  // Control vector bit order:
  // {pc_stall, pc_redirect, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush}
  localparam logic [7:0] E_NONE = 8'b0000_0000;
  localparam logic [7:0] E_LU   = 8'b1010_0100;
  localparam logic [7:0] E_RD   = 8'b0101_0100;
  localparam logic [7:0] E_RF   = 8'b0001_0000;
  localparam logic [7:0] E_MW   = 8'b1010_1011;

  typedef struct packed {
    logic [7:0]  ctl;
    logic [31:0] tgt;
  } exp_t;

  exp_t        sbq[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_stall = 0;
  logic [31:0] exp_redir = 0;

  function automatic logic [7:0] ctl_now();
    return {pc_stall, pc_redirect, if_id_stall, if_id_flush,
            id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = 0; ex_mem_read = 0; ex_redirect = 0; ex_target = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  // Inputs are already applied (just after a rising edge). Queue the expected
  // controls, check them mid-cycle, then check counters after the edge.
  task automatic step(input string tag, input logic [7:0] ctl);
    exp_t e;
    exp_t got;
    e.ctl = ctl;
    e.tgt = ex_target;
    sbq.push_back(e);
    if (ctl[7]) exp_stall = exp_stall + 1;
    if (ctl[6]) exp_redir = exp_redir + 1;
    @(negedge clk);
    if (sbq.size() == 0) begin
      chk({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      got = sbq.pop_front();
      chk({tag, "_ctl"}, {24'd0, ctl_now()}, {24'd0, got.ctl});
      chk({tag, "_tgt"}, pc_target, got.tgt);
    end
    @(posedge clk); #1;
    chk({tag, "_stall_cnt"}, stall_cycles, exp_stall);
    chk({tag, "_redir_cnt"}, redirect_count, exp_redir);
  endtask

  initial begin
    rst_ = 1'b0;
    clr();
    // Active inputs during reset must not leak through.
    ex_redirect = 1; ex_target = 32'h40; dmem_req = 1;
    @(negedge clk);
    chk("rst_ctl", {24'd0, ctl_now()}, 32'd0);
    chk("rst_tgt", pc_target, 32'd0);
    chk("rst_timeout", {31'd0, mem_timeout}, 32'd0);
    chk("rst_stall_cnt", stall_cycles, 32'd0);
    chk("rst_redir_cnt", redirect_count, 32'd0);
    rst_ = 1'b1;
    clr();
    @(posedge clk); #1;

    step("idle", E_NONE);

    // Load-use on rs2: exactly one bubble
    ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
    step("lu_rs2", E_LU);
    clr();
    step("lu_after", E_NONE);

    // Load to x0 never stalls
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    step("x0_load", E_NONE);

    // Matching index but operand not used
    clr(); ex_mem_read = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 0;
    step("lu_unused", E_NONE);
    id_use_rs1 = 1;
    step("lu_rs1", E_LU);

    // Non-load in EX never stalls
    ex_mem_read = 0;
    step("no_load", E_NONE);

    // Redirect, then one refill cycle; load-use suppressed during refill
    clr(); ex_redirect = 1; ex_target = 32'h0000_0040;
    step("redir", E_RD);
    clr(); ex_mem_read = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
    step("refill", E_RF);
    clr();
    step("refill_done", E_NONE);

    // Memory wait suppresses a pending redirect
    ex_redirect = 1; ex_target = 32'h80; dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) step("mw_redir", E_MW);
    chk("mw_no_timeout", {31'd0, mem_timeout}, 32'd0);
    dmem_ready = 1;
    step("mw_release", E_RD);
    clr();
    step("mw_refill", E_RF);
    step("mw_idle", E_NONE);

    // Timeout after 4 consecutive wait cycles, sticky
    dmem_req = 1; dmem_ready = 0;
    for (int k = 1; k <= 6; k++) begin
      step("to_wait", E_MW);
      chk("to_flag", {31'd0, mem_timeout}, (k >= 4) ? 32'd1 : 32'd0);
    end
    dmem_ready = 1;
    step("to_release", E_NONE);
    clr();
    step("to_idle", E_NONE);
    chk("to_sticky", {31'd0, mem_timeout}, 32'd1);

    // Memory wait during refill freezes it; refill resumes afterwards
    ex_redirect = 1; ex_target = 32'h200;
    step("rf_redir", E_RD);
    clr(); dmem_req = 1; dmem_ready = 0;
    step("rf_wait1", E_MW);
    step("rf_wait2", E_MW);
    clr();
    step("rf_resume", E_RF);
    step("rf_done", E_NONE);

    // Redirect during refill restarts it
    ex_redirect = 1; ex_target = 32'h300;
    step("rr_first", E_RD);
    ex_target = 32'h304;
    step("rr_second", E_RD);
    clr();
    step("rr_refill", E_RF);
    step("rr_done", E_NONE);

    // Reset while in refill
    ex_redirect = 1; ex_target = 32'h100;
    step("mr_redir", E_RD);
    clr();
    rst_ = 1'b0;
    ex_redirect = 1; ex_target = 32'h500;
    #1;
    chk("mr_ctl", {24'd0, ctl_now()}, 32'd0);
    chk("mr_tgt", pc_target, 32'd0);
    chk("mr_timeout", {31'd0, mem_timeout}, 32'd0);
    chk("mr_stall_cnt", stall_cycles, 32'd0);
    chk("mr_redir_cnt", redirect_count, 32'd0);
    @(negedge clk);
    rst_ = 1'b1;
    clr();
    exp_stall = 0;
    exp_redir = 0;
    @(posedge clk); #1;
    step("mr_run", E_NONE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
